// File: rtl/spi_flash_wb_reader.sv
// ---------------------------------------------------------------------------
// spi_flash_wb_reader
//
// Read-only Wishbone B3 classic slave that exposes an SPI NOR boot flash
// (EPCS / M25P class) as a block of 32-bit words in the SoC address space.
// Every Wishbone read becomes one complete READ (0x03) flash transaction:
// an 8-bit command, a 24-bit byte address and four data bytes. The flash
// is accessed in SPI mode 0 (SCK idles low, data sampled on the rising edge).
// Write attempts are answered with a single-cycle error and never touch the
// SPI pins.
//
// Parameters
//   CLK_DIV   : wb_clk_i cycles per SCK half-period (>= 1)
//   CS_IDLE   : minimum wb_clk_i cycles with chip select high between two
//               transactions, counted from the acknowledge cycle (>= 1)
//   ADDR_BITS : flash byte-address width; the 0x03 command needs 24
//
// Ports
//   wb_clk_i    : system clock
//   wb_rst_i    : synchronous active-high reset
//   wb_adr_i    : byte address; bits [23:2] select the word, [1:0] ignored
//   wb_dat_o    : read data, first flash byte in [7:0] (little-endian)
//   wb_sel_i    : ignored, a full word is always returned
//   wb_we_i     : write enable; writes are answered with wb_err_o
//   wb_cyc_i    : bus cycle in progress
//   wb_stb_i    : strobe
//   wb_ack_o    : single-cycle read acknowledge
//   wb_err_o    : single-cycle error for write attempts
//   spi_sclk_o  : SPI clock, mode 0
//   spi_cs_n_o  : flash chip select, active low
//   spi_mosi_o  : command / address out, MSB first
//   spi_miso_i  : flash data in
//   busy_o      : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module spi_flash_wb_reader #(
   parameter int CLK_DIV   = 2,
   parameter int CS_IDLE   = 4,
   parameter int ADDR_BITS = 24
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        spi_sclk_o,
   output logic        spi_cs_n_o,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i,
   output logic        busy_o
);

   // Half-period counter width; a divider of 1 still needs a one-bit
   // counter so the vector never collapses to zero width.
   localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   // The deselect counter must be able to hold CS_IDLE and one step beyond
   // it, because the acknowledge cycle already counts as the first cycle.
   localparam int IW = $clog2(CS_IDLE + 2);

   localparam logic [HW-1:0] HALF_MAX  = HW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(CS_IDLE);
   localparam logic [6:0]    LAST_BIT  = 7'd63;
   localparam logic [7:0]    READ_CMD  = 8'h03;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      DONE,
      DESEL,
      WERR
   } state_t;

   state_t          state_q;
   logic [HW-1:0]   halfCnt_q;
   logic [6:0]      bitCnt_q;
   logic [IW-1:0]   idleCnt_q;
   logic [31:0]     txShift_q;
   logic [31:0]     rxShift_q;
   logic [31:0]     dat_q;
   logic            ack_q;
   logic            err_q;
   logic            sclk_q;
   logic            csN_q;
   logic            mosi_q;

   logic [31:0]     txLoad_d;
   logic [31:0]     rxShift_d;
   logic [31:0]     datSwap_d;
   logic            unusedBits;

   // The word that goes out on MOSI for a read: command byte, then the
   // word-aligned flash address. The two low address bits are forced to
   // zero so that every access fetches a whole aligned word.
   always_comb begin
      txLoad_d = {READ_CMD, wb_adr_i[ADDR_BITS-1:2], 2'b00};
   end

   // MISO is sampled MSB first, so after 32 data bits the first byte
   // received sits in the top byte of the shifter. The bus wants the first
   // byte in the bottom byte lane, hence the byte reversal when the word is
   // handed to wb_dat_o.
   always_comb begin
      rxShift_d = {rxShift_q[30:0], spi_miso_i};
      datSwap_d = {rxShift_q[7:0], rxShift_q[15:8],
                   rxShift_q[23:16], rxShift_q[31:24]};
   end

   // Byte lanes and the address bits outside the flash window carry no
   // meaning for this slave; they are folded together only so that the
   // otherwise unread inputs are visibly consumed.
   assign unusedBits = ^{wb_sel_i, wb_adr_i[31:ADDR_BITS], wb_adr_i[1:0]};

   // Main sequencer. All SPI pins and bus responses are registered here so
   // the flash and the bus only ever see glitch-free flop outputs.
   //
   // Timing of a read, with D = CLK_DIV and cycle 0 being the cycle in which
   // the request is sampled in IDLE:
   //   - chip select drops at cycle 1 together with the first MOSI bit;
   //   - each of the 64 bits spends D cycles with SCK low, then D with SCK
   //     high; MOSI changes only at the start of a low phase, so it is
   //     always stable across the following rising edge;
   //   - the flash data bits (32..63) are captured on the clock edge that
   //     raises SCK, which is exactly where a mode-0 slave has them stable;
   //   - the edge that ends the last high phase drops SCK, raises chip
   //     select and pulses the acknowledge, landing on cycle 1 + 128*D.
   // After the acknowledge, or after an abort, chip select stays high in
   // DESEL until CS_IDLE cycles have passed; new requests simply wait on
   // the bus until the sequencer is back in IDLE.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         halfCnt_q <= '0;
         bitCnt_q  <= '0;
         idleCnt_q <= '0;
         txShift_q <= '0;
         rxShift_q <= '0;
         dat_q     <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         sclk_q    <= 1'b0;
         csN_q     <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  if (wb_we_i) begin
                     state_q <= WERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q   <= SHIFT;
                     csN_q     <= 1'b0;
                     sclk_q    <= 1'b0;
                     mosi_q    <= txLoad_d[31];
                     txShift_q <= {txLoad_d[30:0], 1'b0};
                     rxShift_q <= '0;
                     bitCnt_q  <= '0;
                     halfCnt_q <= '0;
                  end
               end
            end

            WERR: begin
               state_q <= IDLE;
            end

            SHIFT: begin
               if (!wb_cyc_i) begin
                  // The master gave up: release the flash at once and
                  // leave wb_dat_o untouched since no word was completed.
                  state_q   <= DESEL;
                  csN_q     <= 1'b1;
                  sclk_q    <= 1'b0;
                  mosi_q    <= 1'b0;
                  halfCnt_q <= '0;
                  idleCnt_q <= IW'(1);
               end else if (halfCnt_q != HALF_MAX) begin
                  halfCnt_q <= halfCnt_q + HW'(1);
               end else begin
                  halfCnt_q <= '0;
                  if (!sclk_q) begin
                     // End of a low phase: raise SCK and, for the data
                     // half of the frame, capture the flash output.
                     sclk_q <= 1'b1;
                     if (bitCnt_q[5]) begin
                        rxShift_q <= rxShift_d;
                     end
                  end else begin
                     // End of a high phase: drop SCK and move to the next
                     // bit, or finish the frame after bit 63.
                     sclk_q   <= 1'b0;
                     bitCnt_q <= bitCnt_q + 7'd1;
                     if (bitCnt_q == LAST_BIT) begin
                        state_q   <= DONE;
                        csN_q     <= 1'b1;
                        mosi_q    <= 1'b0;
                        ack_q     <= 1'b1;
                        dat_q     <= datSwap_d;
                        idleCnt_q <= IW'(1);
                     end else begin
                        // The tx shifter fills with zeros, so MOSI
                        // naturally idles low during the data bytes.
                        mosi_q    <= txShift_q[31];
                        txShift_q <= {txShift_q[30:0], 1'b0};
                     end
                  end
               end
            end

            DONE: begin
               state_q   <= DESEL;
               idleCnt_q <= idleCnt_q + IW'(1);
            end

            DESEL: begin
               if (idleCnt_q >= IDLE_MAX) begin
                  state_q   <= IDLE;
                  idleCnt_q <= '0;
               end else begin
                  idleCnt_q <= idleCnt_q + IW'(1);
               end
            end

            default: begin
               state_q <= IDLE;
               csN_q   <= 1'b1;
               sclk_q  <= 1'b0;
            end
         endcase
      end
   end

   // Bus responses are qualified by wb_cyc_i so that a master which has
   // already abandoned its cycle can never see a stray acknowledge or error.
   assign wb_ack_o   = ack_q & wb_cyc_i;
   assign wb_err_o   = err_q & wb_cyc_i;
   assign wb_dat_o   = dat_q;
   assign spi_sclk_o = sclk_q;
   assign spi_cs_n_o = csN_q;
   assign spi_mosi_o = mosi_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_flash_wb_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_wb_reader
//
// Directed bench for spi_flash_wb_reader. Two instances share the Wishbone
// address/strobe/write lines: instance 0 uses CLK_DIV=2, CS_IDLE=4 and
// instance 1 uses CLK_DIV=1, CS_IDLE=2. Each instance has its own cyc line
// so only the addressed one reacts. A small mode-0 flash model per instance
// captures the command/address stream, returns the bytes of flashData and
// watches SCK/CS/MOSI timing.
// ---------------------------------------------------------------------------
module tb_spi_flash_wb_reader;

   localparam int CLKP = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] adr = '0;
   logic        we  = 1'b0;
   logic        stb = 1'b0;
   logic        cyc [2] = '{1'b0, 1'b0};
   logic [3:0]  sel = 4'hF;

   wire  [31:0] datO    [2];
   wire         ackO    [2];
   wire         errO    [2];
   wire         sclk    [2];
   wire         csn     [2];
   wire         mosi    [2];
   wire         busy    [2];
   wire         miso    [2];
   wire  [31:0] mosiCap [2];
   wire  [31:0] rises   [2];
   wire  [31:0] mosiViol[2];
   wire  [31:0] modeViol[2];
   wire  [31:0] perViol [2];

   logic [31:0] flashData = '0;

   int checks   = 0;
   int failures = 0;

   // Free-running system clock.
   always #(CLKP/2) clk = ~clk;

   spi_flash_wb_reader #(.CLK_DIV(2), .CS_IDLE(4), .ADDR_BITS(24)) u_dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_o(datO[0]),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc[0]), .wb_stb_i(stb),
      .wb_ack_o(ackO[0]), .wb_err_o(errO[0]), .spi_sclk_o(sclk[0]),
      .spi_cs_n_o(csn[0]), .spi_mosi_o(mosi[0]), .spi_miso_i(miso[0]),
      .busy_o(busy[0])
   );

   spi_flash_wb_reader #(.CLK_DIV(1), .CS_IDLE(2), .ADDR_BITS(24)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_o(datO[1]),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc[1]), .wb_stb_i(stb),
      .wb_ack_o(ackO[1]), .wb_err_o(errO[1]), .spi_sclk_o(sclk[1]),
      .spi_cs_n_o(csn[1]), .spi_mosi_o(mosi[1]), .spi_miso_i(miso[1]),
      .busy_o(busy[1])
   );

   // Flash model and pin-timing watchers, one copy per instance.
   for (genvar g = 0; g < 2; g++) begin : gFlash
      localparam int DIVG = (g == 0) ? 2 : 1;
      logic        misoL   = 1'b0;
      int          nRise   = 0;
      logic [31:0] cap     = '0;
      int          mosiV   = 0;
      int          modeV   = 0;
      int          perV    = 0;
      time         lastMosi = 0;
      time         lastRise = 0;
      logic        prevCs  = 1'b1;

      assign miso[g]     = misoL;
      assign mosiCap[g]  = cap;
      assign rises[g]    = nRise;
      assign mosiViol[g] = mosiV;
      assign modeViol[g] = modeV;
      assign perViol[g]  = perV;

      // A new frame starts at the falling chip select.
      always @(negedge csn[g]) begin
         nRise = 0;
         misoL = 1'b0;
      end

      always @(mosi[g]) lastMosi = $time;

      // Rising SCK: capture command/address, check MOSI setup and period.
      always @(posedge sclk[g]) begin
         if (lastMosi == $time) mosiV++;
         if (nRise > 0 && ($time - lastRise) != 2 * DIVG * CLKP) perV++;
         lastRise = $time;
         if (nRise < 32) cap = {cap[30:0], mosi[g]};
         nRise++;
      end

      // Falling SCK: a mode-0 flash presents the next data bit here.
      always @(negedge sclk[g]) begin
         if (nRise >= 32 && nRise < 64)
            misoL = flashData[8 * ((nRise - 32) / 8) + 7 - ((nRise - 32) % 8)];
         else
            misoL = 1'b0;
      end

      // Mode 0: SCK low whenever CS is high and when CS falls.
      always @(negedge clk) begin
         if (rst === 1'b0) begin
            if (csn[g] === 1'b1 && sclk[g] !== 1'b0) modeV++;
            if (prevCs === 1'b1 && csn[g] === 1'b0 && sclk[g] !== 1'b0) modeV++;
         end
         prevCs = csn[g];
      end
   end

   // Advance to just after the next rising clock edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one read on instance g starting in the current cycle (cycle 0)
   // and reports the cycle of the acknowledge (-1 on timeout) plus the chip
   // select level seen in cycle 1. With hold set, cyc/stb stay asserted.
   task automatic applyStimulus(input int g, input logic [31:0] a, input bit hold,
                                output int ackCyc, output logic csAt1);
      int n;
      adr    = a;
      we     = 1'b0;
      stb    = 1'b1;
      cyc[g] = 1'b1;
      ackCyc = -1;
      csAt1  = 1'bx;
      n      = 0;
      while (n < 2000 && ackCyc < 0) begin
         tick();
         n++;
         if (n == 1) csAt1 = csn[g];
         if (ackO[g] === 1'b1) ackCyc = n;
      end
      if (!hold) begin
         stb    = 1'b0;
         cyc[g] = 1'b0;
      end
   endtask

   // Waits (bounded) for instance g to return to idle.
   task automatic waitIdle(input int g, output bit ok);
      int n;
      n = 0;
      while (busy[g] !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      ok = (busy[g] === 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (ackO[g] !== 1'b0 || errO[g] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ack_err inst%0d: ack=%b err=%b, required 0/0", g, ackO[g], errO[g]);
         end
         checks++;
         if (datO[g] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_dat inst%0d: got %h, required 00000000", g, datO[g]);
         end
         checks++;
         if (sclk[g] !== 1'b0 || csn[g] !== 1'b1 || mosi[g] !== 1'b0 || busy[g] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_pins inst%0d: sclk=%b cs_n=%b mosi=%b busy=%b, required 0/1/0/0",
                     g, sclk[g], csn[g], mosi[g], busy[g]);
         end
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read();
      int   c;
      logic cs1;
      bit   ok;
      flashData = 32'h4433_2211;
      applyStimulus(0, 32'h0000_0104, 1'b0, c, cs1);
      checks++;
      if (c != 257) begin
         failures++;
         $display("[TB] FAIL read_ack_cycle: got %0d, required 257", c);
      end
      checks++;
      if (cs1 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL read_cs_cycle1: got %b, required 0", cs1);
      end
      checks++;
      if (mosiCap[0] !== 32'h0300_0104) begin
         failures++;
         $display("[TB] FAIL read_mosi_stream: got %h, required 03000104", mosiCap[0]);
      end
      checks++;
      if (datO[0] !== 32'h4433_2211) begin
         failures++;
         $display("[TB] FAIL read_data: got %h, required 44332211", datO[0]);
      end
      waitIdle(0, ok);
      checks++;
      if (!ok || mosiViol[0] != 0 || modeViol[0] != 0 || perViol[0] != 0) begin
         failures++;
         $display("[TB] FAIL read_timing: idle=%0d mosiViol=%0d modeViol=%0d perViol=%0d, required 1/0/0/0",
                  ok, mosiViol[0], modeViol[0], perViol[0]);
      end
   endtask

   task automatic test_write();
      int   risesBefore;
      int   csLow;
      risesBefore = rises[0];
      csLow = 0;
      adr    = 32'h0000_0200;
      we     = 1'b1;
      stb    = 1'b1;
      cyc[0] = 1'b1;
      tick();
      checks++;
      if (errO[0] !== 1'b1 || ackO[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL write_err_cycle1: err=%b ack=%b, required 1/0", errO[0], ackO[0]);
      end
      if (csn[0] !== 1'b1) csLow++;
      tick();
      checks++;
      if (errO[0] !== 1'b0 || ackO[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL write_err_cycle2: err=%b ack=%b, required 0/0", errO[0], ackO[0]);
      end
      stb    = 1'b0;
      cyc[0] = 1'b0;
      we     = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (csn[0] !== 1'b1) csLow++;
         tick();
      end
      checks++;
      if (csLow != 0 || rises[0] != risesBefore) begin
         failures++;
         $display("[TB] FAIL write_no_spi: csLowCycles=%0d sclkRises=%0d, required 0/0",
                  csLow, rises[0] - risesBefore);
      end
   endtask

   task automatic test_back_to_back();
      int   c;
      int   k;
      int   n;
      int   csHigh;
      logic cs1;
      logic ackNext;
      bit   ok;
      flashData = 32'hDEAD_BEEF;
      applyStimulus(0, 32'h0000_0200, 1'b1, c, cs1);
      checks++;
      if (c != 257 || datO[0] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("[TB] FAIL b2b_first: ackCycle=%0d data=%h, required 257/deadbeef", c, datO[0]);
      end
      adr       = 32'h0012_345B;
      flashData = 32'h0BAD_F00D;
      csHigh = 0;
      k = 0;
      ackNext = 1'bx;
      while (csn[0] === 1'b1 && k < 50) begin
         csHigh++;
         tick();
         k++;
         if (k == 1) ackNext = ackO[0];
      end
      checks++;
      if (ackNext !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_ack_single: ack after ack cycle=%b, required 0", ackNext);
      end
      checks++;
      if (csHigh < 4 || csn[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_cs_gap: high cycles=%0d, required >= 4 then low", csHigh);
      end
      n = 0;
      while (ackO[0] !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      stb    = 1'b0;
      cyc[0] = 1'b0;
      checks++;
      if (n != 256) begin
         failures++;
         $display("[TB] FAIL b2b_second_latency: cs-low to ack=%0d, required 256", n);
      end
      checks++;
      if (mosiCap[0] !== 32'h0312_3458) begin
         failures++;
         $display("[TB] FAIL b2b_mosi_addr: got %h, required 03123458", mosiCap[0]);
      end
      checks++;
      if (datO[0] !== 32'h0BAD_F00D) begin
         failures++;
         $display("[TB] FAIL b2b_second_data: got %h, required 0badf00d", datO[0]);
      end
      waitIdle(0, ok);
   endtask

   task automatic test_abort();
      int   n;
      int   acks;
      int   c;
      logic cs1;
      bit   ok;
      flashData = 32'h1234_5678;
      adr    = 32'h0000_0300;
      we     = 1'b0;
      stb    = 1'b1;
      cyc[0] = 1'b1;
      acks = 0;
      // Bit 40 low phase begins at cycle 1 + 2*40*2 = 161.
      for (n = 1; n <= 161; n++) begin
         tick();
         if (ackO[0] === 1'b1) acks++;
      end
      stb    = 1'b0;
      cyc[0] = 1'b0;
      tick();
      checks++;
      if (csn[0] !== 1'b1 || sclk[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_release: cs_n=%b sclk=%b, required 1/0", csn[0], sclk[0]);
      end
      waitIdle(0, ok);
      checks++;
      if (!ok || acks != 0 || datO[0] !== 32'h0BAD_F00D) begin
         failures++;
         $display("[TB] FAIL abort_no_ack: idle=%0d acks=%0d data=%h, required 1/0/0badf00d",
                  ok, acks, datO[0]);
      end
      flashData = 32'h00FF_7E01;
      applyStimulus(0, 32'h0000_0404, 1'b0, c, cs1);
      checks++;
      if (c != 257 || datO[0] !== 32'h00FF_7E01 || mosiCap[0] !== 32'h0300_0404) begin
         failures++;
         $display("[TB] FAIL abort_next_read: ackCycle=%0d data=%h mosi=%h, required 257/00ff7e01/03000404",
                  c, datO[0], mosiCap[0]);
      end
      waitIdle(0, ok);
   endtask

   task automatic test_reset_mid();
      bit ok;
      flashData = 32'hCAFE_0001;
      adr    = 32'h0000_0500;
      we     = 1'b0;
      stb    = 1'b1;
      cyc[0] = 1'b1;
      // Bit 20 high phase begins at cycle 1 + 80 + 2 = 83 (SCK high).
      repeat (83) tick();
      checks++;
      if (sclk[0] !== 1'b1 || csn[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rstmid_precond: sclk=%b cs_n=%b, required 1/0", sclk[0], csn[0]);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (csn[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b0 || ackO[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rstmid_outputs: cs_n=%b sclk=%b busy=%b ack=%b, required 1/0/0/0",
                  csn[0], sclk[0], busy[0], ackO[0]);
      end
      checks++;
      if (datO[0] !== 32'h0 || mosi[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rstmid_data: dat=%h mosi=%b, required 00000000/0", datO[0], mosi[0]);
      end
      stb    = 1'b0;
      cyc[0] = 1'b0;
      rst    = 1'b0;
      tick();
      waitIdle(0, ok);
   endtask

   task automatic test_fast();
      int   c;
      logic cs1;
      bit   ok;
      flashData = 32'hC001_D00D;
      applyStimulus(1, 32'h00AB_CDEF, 1'b0, c, cs1);
      checks++;
      if (c != 129 || cs1 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL fast_ack_cycle: ackCycle=%0d csAt1=%b, required 129/0", c, cs1);
      end
      checks++;
      if (mosiCap[1] !== 32'h03AB_CDEC || datO[1] !== 32'hC001_D00D) begin
         failures++;
         $display("[TB] FAIL fast_data: mosi=%h data=%h, required 03abcdec/c001d00d", mosiCap[1], datO[1]);
      end
      waitIdle(1, ok);
      checks++;
      if (!ok || mosiViol[1] != 0 || modeViol[1] != 0 || perViol[1] != 0 || rises[1] != 64) begin
         failures++;
         $display("[TB] FAIL fast_timing: idle=%0d mosiViol=%0d modeViol=%0d perViol=%0d rises=%0d, required 1/0/0/0/64",
                  ok, mosiViol[1], modeViol[1], perViol[1], rises[1]);
      end
   endtask

   // Final tally of every comparison made above.
   task automatic checkOutput();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   // Test sequence.
   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_fast();
      checkOutput();
      $finish;
   end

   // Guard against a sequencer that never returns.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time exceeded, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
